// File: rtl/led_matrix_scanner_pkg.sv
// led_pkg: shared frame geometry and scan state encoding for the LED matrix scanner
package led_pkg;
  localparam int ROWS = 16;
  localparam int COLS = 16;
  typedef enum logic [2:0] {FETCH, SHIFT, BLANK, LATCH, DWELL} scan_state_t;
  typedef logic [ROWS-1:0][COLS-1:0] pixel_frame_t;
endpackage

// File: rtl/led_matrix_scanner_if.sv
// led_matrix_scanner_if: board-side pins driven by the scanner
interface led_matrix_scanner_if;
  logic SER_R;
  logic SER_G;
  logic SRCLK;
  logic RCLK;
  logic OE_n;
  logic [3:0] ROW_SEL;
  logic FRAME_START;
  modport master(output SER_R, SER_G, SRCLK, RCLK, OE_n, ROW_SEL, FRAME_START);
  modport slave(input SER_R, SER_G, SRCLK, RCLK, OE_n, ROW_SEL, FRAME_START);
endinterface

// File: rtl/led_matrix_scanner_row_shifter.sv
// led_row_shifter: 16-bit parallel-load register shifting out MSB first
module led_row_shifter
  import led_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load,
  input  logic            shift,
  input  logic [COLS-1:0] din,
  output logic            msb
);
  logic [COLS-1:0] q;
  // load wins over shift; shifting pulls zeros in from the bottom
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) q <= '0;
    else if (load) q <= din;
    else if (shift) q <= {q[COLS-2:0], 1'b0};
  assign msb = q[COLS-1];
endmodule

// File: rtl/led_matrix_scanner.sv
// led_matrix_scanner: snapshots a bicolor frame and scans it row by row onto the LED board
module led_matrix_scanner
  import led_pkg::*;
#(
  parameter int DWELL_CYCLES = 1000
) (
  input  logic         CLK,
  input  logic         RST,
  input  pixel_frame_t RedPixels,
  input  pixel_frame_t GrnPixels,
  led_matrix_scanner_if.master board
);
  localparam int DW = $clog2(DWELL_CYCLES + 1);
  scan_state_t state, state_d;
  logic [3:0] r, bit_cnt, row_sel, row_sel_d;
  logic [DW-1:0] dwell_cnt;
  logic phase, lit, lit_d, load, shift, row_done, red_msb, grn_msb;
  logic ser_r, ser_g, srclk, rclk, oe_n, frame_start;
  logic ser_r_d, ser_g_d, srclk_d, rclk_d, oe_n_d, frame_start_d;
  pixel_frame_t red_buf, grn_buf;
  logic [COLS-1:0] red_row, grn_row;
  assign red_row = (r == 4'd0) ? RedPixels[0] : red_buf[r];
  assign grn_row = (r == 4'd0) ? GrnPixels[0] : grn_buf[r];
  led_row_shifter u_red (.clk(CLK), .rst_n(RST), .load(load), .shift(shift), .din(red_row), .msb(red_msb));
  led_row_shifter u_grn (.clk(CLK), .rst_n(RST), .load(load), .shift(shift), .din(grn_row), .msb(grn_msb));
  // scan state register
  always_ff @(posedge CLK or negedge RST)
    if (!RST) state <= FETCH;
    else state <= state_d;
  // next state and next registered pin values; data is set in phase A so it is stable at the SRCLK rise
  always_comb begin
    state_d = state;
    load = 1'b0;
    shift = 1'b0;
    row_done = 1'b0;
    ser_r_d = ser_r;
    ser_g_d = ser_g;
    srclk_d = 1'b0;
    rclk_d = 1'b0;
    oe_n_d = ~lit;
    frame_start_d = 1'b0;
    row_sel_d = row_sel;
    lit_d = lit;
    case (state)
      FETCH: begin
        load = 1'b1;
        frame_start_d = (r == 4'd0);
        state_d = SHIFT;
      end
      SHIFT: begin
        ser_r_d = phase ? ser_r : red_msb;
        ser_g_d = phase ? ser_g : grn_msb;
        srclk_d = phase;
        shift = phase;
        state_d = (phase && bit_cnt == 4'd15) ? BLANK : SHIFT;
      end
      BLANK: begin
        oe_n_d = 1'b1;
        state_d = LATCH;
      end
      LATCH: begin
        rclk_d = 1'b1;
        row_sel_d = r;
        oe_n_d = 1'b1;
        lit_d = 1'b1;
        state_d = DWELL;
      end
      DWELL: begin
        oe_n_d = 1'b0;
        row_done = (dwell_cnt == DW'(DWELL_CYCLES - 1));
        state_d = row_done ? FETCH : DWELL;
      end
      default: state_d = FETCH;
    endcase
  end
  // row/bit/dwell counters and the frame buffer captured at the start of each frame
  always_ff @(posedge CLK or negedge RST)
    if (!RST) begin
      r <= 4'd0;
      bit_cnt <= 4'd0;
      phase <= 1'b0;
      dwell_cnt <= '0;
      lit <= 1'b0;
      red_buf <= '0;
      grn_buf <= '0;
    end else begin
      lit <= lit_d;
      phase <= (state == SHIFT) ? ~phase : 1'b0;
      bit_cnt <= (state == FETCH) ? 4'd0 : bit_cnt + {3'd0, shift};
      dwell_cnt <= (state == DWELL) ? dwell_cnt + 1'b1 : '0;
      r <= r + {3'd0, row_done};
      if (load && r == 4'd0) begin
        red_buf <= RedPixels;
        grn_buf <= GrnPixels;
      end
    end
  // registered board pins
  always_ff @(posedge CLK or negedge RST)
    if (!RST) begin
      ser_r <= 1'b0;
      ser_g <= 1'b0;
      srclk <= 1'b0;
      rclk <= 1'b0;
      oe_n <= 1'b1;
      row_sel <= 4'd0;
      frame_start <= 1'b0;
    end else begin
      ser_r <= ser_r_d;
      ser_g <= ser_g_d;
      srclk <= srclk_d;
      rclk <= rclk_d;
      oe_n <= oe_n_d;
      row_sel <= row_sel_d;
      frame_start <= frame_start_d;
    end
  assign board.SER_R = ser_r;
  assign board.SER_G = ser_g;
  assign board.SRCLK = srclk;
  assign board.RCLK = rclk;
  assign board.OE_n = oe_n;
  assign board.ROW_SEL = row_sel;
  assign board.FRAME_START = frame_start;
endmodule

// File: tb/tb_led_matrix_scanner.sv
// tb_led_matrix_scanner: directed checks of scan timing, bit order, tear-free snapshot and reset
module tb_led_matrix_scanner;
  import led_pkg::*;
  logic CLK = 1'b0;
  logic RST = 1'b0;
  pixel_frame_t red, grn;
  int checks = 0;
  int errors = 0;
  int cyc = -1;
  int edges = 0;
  int base = 0;
  int fs_count = 0;
  int last_fs = -1;
  logic [15:0] cap_r = '0;
  logic [15:0] cap_g = '0;
  led_matrix_scanner_if ifc ();
  led_matrix_scanner #(.DWELL_CYCLES(4)) dut (
    .CLK(CLK), .RST(RST), .RedPixels(red), .GrnPixels(grn), .board(ifc)
  );
  always #5 CLK = ~CLK;
  // cycle index since reset release: 0 is the cycle after the first FETCH edge
  always @(posedge CLK) cyc <= RST ? cyc + 1 : -1;
  // the board's view: shift in on each SRCLK rise
  always @(posedge ifc.SRCLK) begin
    edges <= edges + 1;
    cap_r <= {cap_r[14:0], ifc.SER_R};
    cap_g <= {cap_g[14:0], ifc.SER_G};
  end
  // frame pulse bookkeeping
  always @(negedge CLK) if (ifc.FRAME_START) begin
    fs_count <= fs_count + 1;
    last_fs <= cyc;
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic goto(input int n);
    while (cyc < n) @(negedge CLK);
  endtask
  task automatic chk_reset_pins(input string tag);
    chk({tag, "_ser_r"}, 32'(ifc.SER_R), 0);
    chk({tag, "_ser_g"}, 32'(ifc.SER_G), 0);
    chk({tag, "_srclk"}, 32'(ifc.SRCLK), 0);
    chk({tag, "_rclk"}, 32'(ifc.RCLK), 0);
    chk({tag, "_oe_n"}, 32'(ifc.OE_n), 1);
    chk({tag, "_row_sel"}, 32'(ifc.ROW_SEL), 0);
    chk({tag, "_frame_start"}, 32'(ifc.FRAME_START), 0);
  endtask
  initial begin
    red = '1;
    grn = '1;
    repeat (5) @(negedge CLK);
    chk_reset_pins("hold_reset");
    chk("reset_srclk_edges", 32'(edges), 0);
    red = '0;
    grn = '0;
    red[0] = 16'hA5C3;
    red[3] = 16'hFF00;
    grn[3] = 16'h00FF;
    RST = 1'b1;
    goto(0);
    base = edges;
    chk("first_frame_start", 32'(ifc.FRAME_START), 1);
    chk("first_oe_n", 32'(ifc.OE_n), 1);
    goto(1);
    chk("phase_a_srclk", 32'(ifc.SRCLK), 0);
    chk("phase_a_ser_r", 32'(ifc.SER_R), 1);
    goto(2);
    chk("phase_b_srclk", 32'(ifc.SRCLK), 1);
    goto(10);
    chk("unlit_oe_n", 32'(ifc.OE_n), 1);
    goto(33);
    chk("row0_edges", 32'(edges - base), 16);
    chk("row0_ser_r", 32'(cap_r), 32'hA5C3);
    chk("row0_ser_g", 32'(cap_g), 0);
    chk("blank_oe_n", 32'(ifc.OE_n), 1);
    chk("blank_rclk", 32'(ifc.RCLK), 0);
    goto(34);
    chk("latch_rclk", 32'(ifc.RCLK), 1);
    chk("latch_row_sel", 32'(ifc.ROW_SEL), 0);
    chk("latch_oe_n", 32'(ifc.OE_n), 1);
    for (int i = 35; i < 39; i++) begin
      goto(i);
      chk("dwell_oe_n", 32'(ifc.OE_n), 0);
    end
    goto(39);
    chk("row1_fetch_frame_start", 32'(ifc.FRAME_START), 0);
    chk("row1_fetch_oe_n", 32'(ifc.OE_n), 0);
    chk("row1_fetch_rclk", 32'(ifc.RCLK), 0);
    for (int r = 1; r < 16; r++) begin
      if (r == 3) begin
        goto(150);
        chk("bicolor_ser_r", 32'(cap_r), 32'hFF00);
        chk("bicolor_ser_g", 32'(cap_g), 32'h00FF);
        chk("row3_edges", 32'(edges - base), 64);
      end
      goto(39 * r + 36);
      chk("row_sel_step", 32'(ifc.ROW_SEL), 32'(r));
    end
    goto(620);
    red = '1;
    goto(624);
    chk("frame2_start", 32'(ifc.FRAME_START), 1);
    goto(629);
    chk("frame_start_count", 32'(fs_count), 2);
    chk("frame_start_period", 32'(last_fs), 624);
    goto(657);
    chk("row_sel_15", 32'(ifc.ROW_SEL), 15);
    goto(658);
    chk("row_sel_wrap", 32'(ifc.ROW_SEL), 0);
    goto(824);
    red = '0;
    goto(852);
    chk("tear_row5", 32'(cap_r), 32'hFFFF);
    goto(1242);
    chk("tear_row15", 32'(cap_r), 32'hFFFF);
    goto(1281);
    chk("next_frame_row0", 32'(cap_r), 0);
    goto(1635);
    chk("pre_reset_row_sel", 32'(ifc.ROW_SEL), 9);
    chk("pre_reset_oe_n", 32'(ifc.OE_n), 0);
    RST = 1'b0;
    #1;
    chk_reset_pins("async_reset");
    red = '0;
    red[0] = 16'h0F0F;
    red[1] = 16'h8001;
    repeat (2) @(negedge CLK);
    RST = 1'b1;
    goto(0);
    chk("restart_frame_start", 32'(ifc.FRAME_START), 1);
    goto(10);
    chk("restart_oe_n", 32'(ifc.OE_n), 1);
    goto(33);
    chk("restart_row0", 32'(cap_r), 32'h0F0F);
    goto(34);
    chk("restart_row_sel", 32'(ifc.ROW_SEL), 0);
    chk("restart_rclk", 32'(ifc.RCLK), 1);
    goto(72);
    chk("restart_row1", 32'(cap_r), 32'h8001);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/led_matrix_scanner.md
# led_matrix_scanner

Display-side consumer of the 16x16 bicolor pixel frames produced by pattern generators. Snapshots `RedPixels`/`GrnPixels` once per frame and scans them row by row onto the LED board: 16 red and 16 green column bits are shifted serially into the board's column shift registers, latched, and the matching row is enabled for a fixed dwell time. Sits between any frame-producing module and the board pins.

## Interface
- `DWELL_CYCLES`, 1000, cycles a row is lit per scan; must be ≥ 1.
- `CLK`  in  1  system clock; all logic on rising edge.
- `RST`  in  1  asynchronous, active-low reset.
- `RedPixels`  in  [15:0][15:0]  red frame, `[row][col]`, 1 = lit.
- `GrnPixels`  in  [15:0][15:0]  green frame, same layout.
- `SER_R`  out  1  red column serial data.
- `SER_G`  out  1  green column serial data.
- `SRCLK`  out  1  column shift clock; board shifts on rising edge.
- `RCLK`  out  1  column latch strobe, one cycle high.
- `OE_n`  out  1  active-low column output enable (blanking).
- `ROW_SEL`  out  4  index of the row currently driven.
- `FRAME_START`  out  1  one-cycle pulse when a new frame is snapshotted.

## Operation
- FSM: FETCH → SHIFT → BLANK → LATCH → DWELL → FETCH.
- FETCH (1 cycle): load red/green row shift registers with row `r` (r = next row, 0..15). When r = 0, also snapshot full `RedPixels`/`GrnPixels` into the frame buffer and pulse `FRAME_START`; row 0 is loaded directly from the inputs in that cycle. Rows 1..15 come from the buffer, so input changes mid-frame never tear.
- SHIFT (32 cycles): 16 bits, column 15 first, 2 cycles per bit. Phase A: `SER_R`/`SER_G` = current bit, `SRCLK` = 0. Phase B: same data, `SRCLK` = 1. Shift register advances after phase B.
- BLANK (1 cycle): `OE_n` = 1, `SRCLK` = 0.
- LATCH (1 cycle): `RCLK` = 1, `ROW_SEL` ← r, `OE_n` = 1.
- DWELL (`DWELL_CYCLES` cycles): `OE_n` = 0; on last cycle r ← r+1 mod 16 (15 wraps to 0), go to FETCH.
- `OE_n` = 0 during FETCH/SHIFT/DWELL (previous row stays lit while next shifts), except before the first LATCH after reset, when it stays 1.
- No input handshake; inputs sampled only in FETCH of row 0.

## Timing
- Reset values: `SER_R`=0, `SER_G`=0, `SRCLK`=0, `RCLK`=0, `OE_n`=1, `ROW_SEL`=0, `FRAME_START`=0; state FETCH, r=0, frame buffer all 0, lit-flag cleared.
- First rising edge after `RST` deasserts is FETCH of row 0 (`FRAME_START`=1 in that cycle).
- Row period = `DWELL_CYCLES` + 35 cycles; frame period = 16 × that.
- All outputs registered; no combinational input→output path.
- Dwell counter width = $clog2(`DWELL_CYCLES`+1); bit counter 4 bits, phase 1 bit.
- Reset asserted mid-operation (any state): outputs go to reset values immediately (asynchronous), scan restarts at row 0 with a fresh snapshot.

## Structure
- Package `led_pkg`: `ROWS`=16, `COLS`=16, state enum `scan_state_t` {FETCH, SHIFT, BLANK, LATCH, DWELL}, `pixel_frame_t` = logic [15:0][15:0].
- Sub-module `led_row_shifter`: 16-bit parallel-load, MSB-first shift register with load/shift enables; instantiated twice (red, green).

## Test plan
- Reset: hold `RST`=0 with nonzero frames → all outputs at reset values, `OE_n`=1, no `SRCLK` edges.
- Single row, `DWELL_CYCLES`=4: Red row0 = 16'hA5C3, green 0 → 16 `SRCLK` rising edges with `SER_R` sequence 1010010111000011, `SER_G` all 0; `RCLK` at cycle 34 with `ROW_SEL`=0; `OE_n`=0 for next 4 cycles.
- Full frame, `DWELL_CYCLES`=4: `ROW_SEL` steps 0..15 every 39 cycles, wraps to 0; `FRAME_START` exactly every 624 cycles.
- Tear-free: change `RedPixels` from all-1 to all-0 during row 5 SHIFT → rows 5..15 still shift all-1; next frame shifts all-0.
- Reset mid-DWELL of row 9 → outputs immediately reset; after release, `FRAME_START` on first cycle and `ROW_SEL` latches 0.
- Bicolor: red row 3 = 16'hFF00, green row 3 = 16'h00FF → `SER_R` 1 for first 8 bits, `SER_G` 1 for last 8 bits.
